// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: MemOP codes, FSM state type
// and the request legality check used at handshake time.
package lsu_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  // Returns 1 when the request can never reach the bus: conflicting
  // load+store flags, an unknown MemOP (unsigned ops are load-only), or a
  // halfword/word access that is not naturally aligned.
  function automatic logic lsu_req_err(input logic       memwr,
                                       input logic       memtoreg,
                                       input logic [2:0] memop,
                                       input logic [1:0] offset);
    logic err;
    err = 1'b0;
    if (memwr && memtoreg) err = 1'b1;
    case (memop)
      MEMOP_B:  ;
      MEMOP_BU: if (memwr) err = 1'b1;
      MEMOP_H:  if (offset[0]) err = 1'b1;
      MEMOP_HU: if (memwr || offset[0]) err = 1'b1;
      MEMOP_W:  if (offset != 2'b00) err = 1'b1;
      default:  err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for a 32-bit word bus: builds the write mask and
// lane-replicated write data for stores, and extracts/extends load data
// from a full aligned word. Purely combinational.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  memop,
  input  logic [1:0]  offset,
  input  logic [31:0] data,
  input  logic [31:0] word,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  // Store side: mask follows the access size shifted to the byte offset.
  always_comb begin
    wmask = 4'b1111;
    wdata = data;
    case (memop)
      MEMOP_B, MEMOP_BU: begin
        wmask = 4'b0001 << offset;
        wdata = {4{data[7:0]}};
      end
      MEMOP_H, MEMOP_HU: begin
        wmask = 4'b0011 << offset;
        wdata = {2{data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load side: shift the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted = word >> {offset, 3'b000};
    rdata   = word;
    case (memop)
      MEMOP_B:  rdata = {{24{shifted[7]}}, shifted[7:0]};
      MEMOP_BU: rdata = {24'h0, shifted[7:0]};
      MEMOP_H:  rdata = {{16{shifted[15]}}, shifted[15:0]};
      MEMOP_HU: rdata = {16'h0, shifted[15:0]};
      default:  ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Multi-cycle load/store unit between the EX stage and a valid/ready data
// bus. One access in flight; the core stalls while req_ready is low.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready for a request; latches it on handshake
//   REQ     | bus request presented, held stable until mem_req_ready
//   WAIT    | request accepted, waiting for mem_rsp_valid
//   DONE    | one-cycle resp_valid with registered data/error
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_memwr,
  input  logic              req_memtoreg,
  input  logic [2:0]        req_memop,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [3:0]        mem_req_wmask,
  output logic [XLEN-1:0]   mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_rdata
);

  lsu_state_t  state, state_nxt;
  logic [2:0]  memop_q;
  logic [1:0]  off_q;
  logic        wr_q;
  logic        hs;
  logic        req_err;
  logic [2:0]  align_memop;
  logic [1:0]  align_off;
  logic [3:0]  lane_wmask;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  assign hs      = (state == ST_IDLE) && req_valid && (req_memwr || req_memtoreg);
  assign req_err = lsu_req_err(req_memwr, req_memtoreg, req_memop, req_addr[1:0]);

  // In IDLE the aligner serves the incoming store; afterwards it serves the
  // latched op so the returning word is extracted with the right lane.
  assign align_memop = (state == ST_IDLE) ? req_memop     : memop_q;
  assign align_off   = (state == ST_IDLE) ? req_addr[1:0] : off_q;

  lsu_lane_align u_lane_align (
    .memop  (align_memop),
    .offset (align_off),
    .data   (req_wdata),
    .word   (mem_rsp_rdata),
    .wmask  (lane_wmask),
    .wdata  (lane_wdata),
    .rdata  (lane_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and state-decoded handshake outputs.
  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    resp_valid    = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (hs) state_nxt = req_err ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rsp_valid) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request latch on handshake and load-data capture on the bus response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memop_q       <= 3'b000;
      off_q         <= 2'b00;
      wr_q          <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_wmask <= 4'b0000;
      mem_req_wdata <= '0;
      resp_rdata    <= '0;
      resp_err      <= 1'b0;
    end else if (hs) begin
      memop_q       <= req_memop;
      off_q         <= req_addr[1:0];
      wr_q          <= req_memwr;
      mem_req_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
      mem_req_wen   <= req_memwr && !req_err;
      mem_req_wmask <= (req_memwr && !req_err) ? lane_wmask : 4'b0000;
      mem_req_wdata <= req_memwr ? lane_wdata : '0;
      resp_rdata    <= '0;
      resp_err      <= req_err;
    end else if ((state == ST_WAIT) && mem_rsp_valid && !wr_q) begin
      resp_rdata <= lane_rdata;
    end
  end

endmodule
